// File: rtl/step_tick_gen.sv
// step_tick_gen: input conditioning and soft-start step clock-enable for the
// stepper phase sequencer. SENSE and OPP are synchronised and debounced; the
// step period ramps linearly from DIV_START down to DIV_MIN and restarts the
// ramp on each direction change.
module step_tick_gen #(
  parameter int CW        = 20,
  parameter int DIV_START = 50000,
  parameter int DIV_MIN   = 10000,
  parameter int DIV_DEC   = 1000,
  parameter int DB_CYCLES = 20000
) (
  input  logic          CLK,
  input  logic          RESETN,
  input  logic          ENABLE,
  input  logic          SENSE_RAW,
  input  logic          OPP_RAW,
  output logic          STEP_TICK,
  output logic          SENSE_PULSE,
  output logic          OPP_LVL,
  output logic          OPP_CHG,
  output logic [CW-1:0] PERIOD,
  output logic          RUNNING
);

  localparam logic [CW-1:0] START_C = CW'(DIV_START);
  localparam logic [CW-1:0] MIN_C   = CW'(DIV_MIN);
  localparam logic [CW-1:0] DEC_C   = CW'(DIV_DEC);
  localparam logic [CW-1:0] DB_LAST = CW'(DB_CYCLES - 1);
  localparam logic [CW-1:0] ONE_C   = CW'(1);

  typedef enum logic [1:0] {IDLE, ACCEL, CRUISE} state_e;

  // Period never drops below DIV_MIN; the subtraction is guarded so it cannot wrap.
  function automatic logic [CW-1:0] sat_dec(input logic [CW-1:0] p);
    if ((p - MIN_C) > DEC_C) return p - DEC_C;
    else                     return MIN_C;
  endfunction

  logic          sense_s1_q, sense_s2_q;
  logic          opp_s1_q, opp_s2_q, opp_prev_q;
  logic          sense_db_q, sense_db_d;
  logic [CW-1:0] sense_cnt_q, sense_cnt_d;
  logic          sense_pulse_q, sense_pulse_d;
  logic          opp_lvl_q, opp_lvl_d;
  logic          opp_primed_q, opp_primed_d;
  logic [CW-1:0] opp_cnt_q, opp_cnt_d;
  logic [CW-1:0] opp_run;
  logic          opp_chg_q, opp_chg_d;
  state_e        state_q, state_d;
  logic [CW-1:0] tick_cnt_q, tick_cnt_d;
  logic [CW-1:0] period_q, period_d;
  logic          term_cnt;
  logic          step_tick;

  // Two-flop synchronisers; opp_prev_q tracks the previous synced OPP for the priming run length.
  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      sense_s1_q <= 1'b0;
      sense_s2_q <= 1'b0;
      opp_s1_q   <= 1'b0;
      opp_s2_q   <= 1'b0;
      opp_prev_q <= 1'b0;
    end else begin
      sense_s1_q <= SENSE_RAW;
      sense_s2_q <= sense_s1_q;
      opp_s1_q   <= OPP_RAW;
      opp_s2_q   <= opp_s1_q;
      opp_prev_q <= opp_s2_q;
    end
  end

  // SENSE debounce: flip after DB_CYCLES consecutive differing cycles, pulse on a rise.
  always_comb begin
    sense_cnt_d   = '0;
    sense_db_d    = sense_db_q;
    sense_pulse_d = 1'b0;
    if (sense_s2_q != sense_db_q) begin
      if (sense_cnt_q == DB_LAST) begin
        sense_db_d    = sense_s2_q;
        sense_pulse_d = sense_s2_q;
      end else begin
        sense_cnt_d = sense_cnt_q + ONE_C;
      end
    end
  end

  // OPP debounce: before priming, any value stable for DB_CYCLES is adopted silently.
  always_comb begin
    opp_cnt_d    = '0;
    opp_lvl_d    = opp_lvl_q;
    opp_primed_d = opp_primed_q;
    opp_chg_d    = 1'b0;
    opp_run      = '0;
    if (!opp_primed_q) begin
      if (opp_s2_q == opp_prev_q) opp_run = opp_cnt_q;
      if (opp_run == DB_LAST) begin
        opp_primed_d = 1'b1;
        opp_lvl_d    = opp_s2_q;
      end else begin
        opp_cnt_d = opp_run + ONE_C;
      end
    end else if (opp_s2_q != opp_lvl_q) begin
      if (opp_cnt_q == DB_LAST) begin
        opp_lvl_d = opp_s2_q;
        opp_chg_d = 1'b1;
      end else begin
        opp_cnt_d = opp_cnt_q + ONE_C;
      end
    end
  end

  // Debounce state and registered edge pulses.
  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      sense_db_q    <= 1'b0;
      sense_cnt_q   <= '0;
      sense_pulse_q <= 1'b0;
      opp_lvl_q     <= 1'b0;
      opp_primed_q  <= 1'b0;
      opp_cnt_q     <= '0;
      opp_chg_q     <= 1'b0;
    end else begin
      sense_db_q    <= sense_db_d;
      sense_cnt_q   <= sense_cnt_d;
      sense_pulse_q <= sense_pulse_d;
      opp_lvl_q     <= opp_lvl_d;
      opp_primed_q  <= opp_primed_d;
      opp_cnt_q     <= opp_cnt_d;
      opp_chg_q     <= opp_chg_d;
    end
  end

  // Ramp FSM next state: ENABLE drop beats direction restart, which beats the tick.
  always_comb begin
    state_d    = state_q;
    tick_cnt_d = tick_cnt_q;
    period_d   = period_q;
    step_tick  = 1'b0;
    term_cnt   = (tick_cnt_q == (period_q - ONE_C));
    case (state_q)
      IDLE: begin
        tick_cnt_d = '0;
        period_d   = START_C;
        if (ENABLE) state_d = ACCEL;
      end
      ACCEL, CRUISE: begin
        if (!ENABLE) begin
          state_d    = IDLE;
          tick_cnt_d = '0;
          period_d   = START_C;
        end else if (opp_chg_q) begin
          state_d    = ACCEL;
          tick_cnt_d = '0;
          period_d   = START_C;
        end else if (term_cnt) begin
          step_tick  = 1'b1;
          tick_cnt_d = '0;
          if (state_q == ACCEL) begin
            period_d = sat_dec(period_q);
            if (period_d == MIN_C) state_d = CRUISE;
          end
        end else begin
          tick_cnt_d = tick_cnt_q + ONE_C;
        end
      end
      default: begin
        state_d    = IDLE;
        tick_cnt_d = '0;
        period_d   = START_C;
      end
    endcase
  end

  // Ramp FSM state, tick counter and current period.
  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      state_q    <= IDLE;
      tick_cnt_q <= '0;
      period_q   <= START_C;
    end else begin
      state_q    <= state_d;
      tick_cnt_q <= tick_cnt_d;
      period_q   <= period_d;
    end
  end

  assign STEP_TICK   = step_tick;
  assign SENSE_PULSE = sense_pulse_q;
  assign OPP_LVL     = opp_lvl_q;
  assign OPP_CHG     = opp_chg_q;
  assign PERIOD      = period_q;
  assign RUNNING     = (state_q != IDLE);

endmodule

// File: tb/tb_step_tick_gen.sv
// tb_step_tick_gen: directed scenarios plus a randomized run, every cycle
// compared against a behavioural model built from debounce windows and a
// ramp schedule.
module tb_step_tick_gen;

  localparam int CW      = 8;
  localparam int P_START = 10;
  localparam int P_MIN   = 4;
  localparam int P_DEC   = 3;
  localparam int DB      = 4;
  localparam int MAXC    = 6000;

  logic          CLK = 1'b0;
  logic          RESETN = 1'b0;
  logic          ENABLE = 1'b0;
  logic          SENSE_RAW = 1'b0;
  logic          OPP_RAW = 1'b0;
  logic          STEP_TICK, SENSE_PULSE, OPP_LVL, OPP_CHG, RUNNING;
  logic [CW-1:0] PERIOD;

  step_tick_gen #(
    .CW(CW), .DIV_START(P_START), .DIV_MIN(P_MIN), .DIV_DEC(P_DEC), .DB_CYCLES(DB)
  ) dut (
    .CLK(CLK), .RESETN(RESETN), .ENABLE(ENABLE), .SENSE_RAW(SENSE_RAW), .OPP_RAW(OPP_RAW),
    .STEP_TICK(STEP_TICK), .SENSE_PULSE(SENSE_PULSE), .OPP_LVL(OPP_LVL), .OPP_CHG(OPP_CHG),
    .PERIOD(PERIOD), .RUNNING(RUNNING)
  );

  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  bit obs_tick [MAXC];
  bit obs_chg  [MAXC];
  bit obs_sp   [MAXC];

  // behavioural model state
  bit m_run, m_cruise, m_chg, m_sp, m_sdb, m_ol, m_primed;
  bit m_s1s, m_s2s, m_s1o, m_s2o;
  int m_elapsed, m_period;
  bit hs[$];
  bit ho[$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s (cycle %0d): got %0d, expected %0d", tag, cyc, got, want);
    end
  endtask

  function automatic bit all_val(input bit q[$], input bit v);
    if (q.size() < DB) return 1'b0;
    foreach (q[i]) if (q[i] != v) return 1'b0;
    return 1'b1;
  endfunction

  task automatic model_reset();
    m_run = 0; m_cruise = 0; m_chg = 0; m_sp = 0; m_sdb = 0; m_ol = 0; m_primed = 0;
    m_s1s = 0; m_s2s = 0; m_s1o = 0; m_s2o = 0;
    m_elapsed = 0; m_period = P_START;
    hs.delete(); ho.delete();
  endtask

  // One active clock edge of the model, using the inputs held across that edge.
  task automatic model_edge();
    bit due;
    due = m_run && ENABLE && !m_chg && (m_elapsed + 1 == m_period);
    if (!m_run) begin
      if (ENABLE) begin m_run = 1; m_cruise = 0; m_elapsed = 0; m_period = P_START; end
    end else if (!ENABLE) begin
      m_run = 0; m_cruise = 0; m_elapsed = 0; m_period = P_START;
    end else if (m_chg) begin
      m_cruise = 0; m_elapsed = 0; m_period = P_START;
    end else if (due) begin
      m_elapsed = 0;
      if (!m_cruise) begin
        m_period = (m_period - P_DEC < P_MIN) ? P_MIN : m_period - P_DEC;
        if (m_period == P_MIN) m_cruise = 1;
      end
    end else begin
      m_elapsed++;
    end
    hs.push_back(m_s2s);
    if (hs.size() > DB) void'(hs.pop_front());
    m_sp = 0;
    if (all_val(hs, !m_sdb)) begin m_sdb = !m_sdb; m_sp = m_sdb; end
    ho.push_back(m_s2o);
    if (ho.size() > DB) void'(ho.pop_front());
    m_chg = 0;
    if (!m_primed) begin
      if (all_val(ho, ho[ho.size()-1])) begin m_primed = 1; m_ol = ho[ho.size()-1]; end
    end else if (all_val(ho, !m_ol)) begin
      m_ol = !m_ol; m_chg = 1;
    end
    m_s2s = m_s1s; m_s1s = SENSE_RAW;
    m_s2o = m_s1o; m_s1o = OPP_RAW;
  endtask

  task automatic clk_cycle(input bit en_v, input bit s_v, input bit o_v);
    bit want_tick;
    @(posedge CLK);
    model_edge();
    #1;
    ENABLE = en_v; SENSE_RAW = s_v; OPP_RAW = o_v;
    cyc++;
    @(negedge CLK);
    want_tick = m_run && ENABLE && !m_chg && (m_elapsed + 1 == m_period);
    check_eq("step_tick", STEP_TICK, want_tick);
    check_eq("sense_pulse", SENSE_PULSE, m_sp);
    check_eq("opp_lvl", OPP_LVL, m_ol);
    check_eq("opp_chg", OPP_CHG, m_chg);
    check_eq("period", PERIOD, m_period);
    check_eq("running", RUNNING, m_run);
    if (cyc < MAXC) begin
      obs_tick[cyc] = STEP_TICK; obs_chg[cyc] = OPP_CHG; obs_sp[cyc] = SENSE_PULSE;
    end
  endtask

  function automatic int next_tick(input int after);
    for (int k = after + 1; k <= cyc && k < MAXC; k++) if (obs_tick[k]) return k;
    return -1000;
  endfunction

  function automatic int next_chg(input int after);
    for (int k = after + 1; k <= cyc && k < MAXC; k++) if (obs_chg[k]) return k;
    return -1000;
  endfunction

  function automatic int count_chg(input int a, input int b);
    int n = 0;
    for (int k = a; k <= b && k < MAXC; k++) if (obs_chg[k]) n++;
    return n;
  endfunction

  function automatic int count_sp(input int a, input int b);
    int n = 0;
    for (int k = a; k <= b && k < MAXC; k++) if (obs_sp[k]) n++;
    return n;
  endfunction

  initial begin
    #400000;
    $display("FAIL watchdog: time %0t exceeded limit 400000", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int st, k, t, n;
    int iv[5];
    bit e, s, o;
    model_reset();
    OPP_RAW = 1'b1;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    check_eq("rst_period", PERIOD, P_START);
    check_eq("rst_running", RUNNING, 0);
    check_eq("rst_step_tick", STEP_TICK, 0);
    check_eq("rst_opp_lvl", OPP_LVL, 0);
    RESETN = 1'b1;

    // 1: priming with a held 1, then a real change
    st = cyc;
    repeat (8) clk_cycle(0, 0, 1);
    check_eq("t1_opp_lvl_primed", OPP_LVL, 1);
    check_eq("t1_no_chg_on_prime", count_chg(st + 1, cyc), 0);
    st = cyc;
    repeat (10) clk_cycle(0, 0, 0);
    check_eq("t1_chg_count", count_chg(st + 1, cyc), 1);
    check_eq("t1_opp_lvl_low", OPP_LVL, 0);

    // 2: soft-start ramp into cruise
    st = cyc + 1;
    repeat (40) clk_cycle(1, 0, 0);
    iv = '{10, 7, 4, 4, 4};
    t = st;
    for (int i = 0; i < 5; i++) begin
      k = next_tick(t);
      check_eq($sformatf("t2_interval%0d", i), k - t, iv[i]);
      t = k;
    end
    check_eq("t2_running", RUNNING, 1);
    check_eq("t2_cruise_period", PERIOD, P_MIN);

    // 3: short sense glitches rejected, long hold gives one pulse
    st = cyc;
    for (int g = 1; g <= 3; g++) begin
      repeat (g) clk_cycle(1, 1, 0);
      repeat (6) clk_cycle(1, 0, 0);
    end
    check_eq("t3_glitch_pulses", count_sp(st + 1, cyc), 0);
    st = cyc;
    repeat (6) clk_cycle(1, 1, 0);
    repeat (8) clk_cycle(1, 0, 0);
    check_eq("t3_hold_pulses", count_sp(st + 1, cyc), 1);

    // 4: direction change landing on a terminal count
    n = 0;
    while (!(m_run && m_cruise && !m_chg && m_elapsed == 0) && n < 20) begin
      clk_cycle(1, 0, 0); n++;
    end
    check_eq("t4_align_bound", n < 20, 1);
    st = cyc + 1;
    repeat (30) clk_cycle(1, 0, 1);
    k = next_chg(st - 1);
    check_eq("t4_chg_latency", k - st, 6);
    if (k > 4) begin
      check_eq("t4_tick_suppressed", obs_tick[k], 0);
      check_eq("t4_prior_cadence", obs_tick[k - 4], 1);
    end
    iv = '{10, 7, 4, 0, 0};
    t = k;
    for (int i = 0; i < 3; i++) begin
      k = next_tick(t);
      check_eq($sformatf("t4_interval%0d", i), k - t, iv[i]);
      t = k;
    end

    // 5: ENABLE dropped in the tick-due cycle
    n = 0;
    while (!(m_run && m_cruise && !m_chg && m_elapsed == m_period - 2) && n < 20) begin
      clk_cycle(1, 0, 1); n++;
    end
    check_eq("t5_align_bound", n < 20, 1);
    clk_cycle(0, 0, 1);
    check_eq("t5_tick_dropped", obs_tick[cyc], 0);
    check_eq("t5_prior_cadence", obs_tick[cyc - 4], 1);
    clk_cycle(0, 0, 1);
    check_eq("t5_idle_running", RUNNING, 0);
    check_eq("t5_idle_period", PERIOD, P_START);
    clk_cycle(0, 0, 1);
    st = cyc + 1;
    repeat (12) clk_cycle(1, 0, 1);
    check_eq("t5_reenable_first", next_tick(st) - st, 10);
    check_eq("t6_pre_period", PERIOD, 7);

    // 6: asynchronous reset mid-ACCEL
    #2 RESETN = 1'b0;
    #1;
    check_eq("t6_rst_step_tick", STEP_TICK, 0);
    check_eq("t6_rst_sense_pulse", SENSE_PULSE, 0);
    check_eq("t6_rst_opp_lvl", OPP_LVL, 0);
    check_eq("t6_rst_opp_chg", OPP_CHG, 0);
    check_eq("t6_rst_period", PERIOD, P_START);
    check_eq("t6_rst_running", RUNNING, 0);
    model_reset();
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    RESETN = 1'b1;
    st = cyc;
    repeat (12) clk_cycle(0, 0, 1);
    check_eq("t6_no_chg_after_rst", count_chg(st + 1, cyc), 0);
    check_eq("t6_opp_lvl_reprimed", OPP_LVL, 1);

    // randomized run against the model
    e = 0; s = 0; o = 1;
    repeat (3000) begin
      if ($urandom_range(0, 39) == 0) e = !e;
      if ($urandom_range(0, 4) == 0) s = !s;
      if ($urandom_range(0, 9) == 0) o = !o;
      clk_cycle(e, s, o);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
